apb_regfile_param: RTL and testbench
====================================

Name: apb_regfile_param

Overview:
- Parametrised successor of the fixed 16-entry APB register file.
- Register count, reset values and per-register access mode (RW / RO / W1C) are set by parameters.
- Adds a registered read-data valid strobe, an error flag for bad accesses, hardware-side update ports for status registers, and an interrupt output.
- Sits behind the APB slave interface in the bridge; the host side uses the same addr/read_en/write_en/byte_strobe/wdata/rdata protocol as the existing register file.

Parameters:
- DATA_WIDTH, 32, register and bus data width (multiple of 8).
- ADDR_WIDTH, 32, host address width.
- NUM_REGS, 16, number of registers (1..64). Register i sits at byte address 4*i.
- NBYTES, DATA_WIDTH/8, number of byte strobes.
- RO_MASK, all 0, NUM_REGS bits; bit i=1 makes register i read-only from the host.
- W1C_MASK, all 0, NUM_REGS bits; bit i=1 makes register i write-1-to-clear. RO_MASK takes priority if both are set.
- RESET_VALUES, all 0, NUM_REGS*DATA_WIDTH bits; slice i is the reset value of register i.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_WIDTH  host byte address.
- read_en  in  1  host read request, one cycle.
- write_en  in  1  host write request, one cycle.
- byte_strobe  in  NBYTES  write byte enables.
- wdata  in  DATA_WIDTH  host write data.
- rdata  out  DATA_WIDTH  registered read data.
- rdata_valid  out  1  one-cycle pulse; rdata is valid in the same cycle.
- err  out  1  one-cycle pulse; the access one cycle earlier was invalid.
- hw_wr_en  in  NUM_REGS  per-register hardware load strobe (RO registers only).
- hw_wdata  in  NUM_REGS*DATA_WIDTH  hardware load data.
- hw_set  in  NUM_REGS*DATA_WIDTH  hardware bit-set pulses (W1C registers only).
- reg_out  out  NUM_REGS*DATA_WIDTH  current contents of all registers.
- irq  out  1  registered OR of all bits of all W1C registers.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge; also applies mid-access):
  - register i loads RESET_VALUES slice i;
  - rdata=0, rdata_valid=0, err=0, irq=0;
  - any access in flight is dropped with no valid or error pulse.
- Address decode: an access is valid when all of the following hold:
  - addr[1:0]==0;
  - idx=addr>>2 < NUM_REGS;
  - all addr bits above the index field are 0.
- Write, registered, effective at the next edge:
  - RW register: reg = (reg & ~mask) | (wdata & mask), where mask is byte_strobe expanded to bits.
  - RO register: host write ignored, no error.
  - W1C register: reg = reg & ~(wdata & mask).
  - byte_strobe=0: no change, no error.
- Hardware updates, every cycle:
  - RO register i: if hw_wr_en[i], reg_i <= hw_wdata slice i.
  - W1C register i: reg_i |= hw_set slice i.
  - hw_wr_en and hw_set are ignored on registers of other modes.
- Simultaneous events on one W1C bit: hardware set wins over host clear.
- Read:
  - read_en with a valid addr: rdata <= register value one cycle later, rdata_valid=1 for exactly one cycle.
  - rdata holds its last value when no read occurs.
  - Read and write to the same address in one cycle: rdata returns the pre-write value.
- Invalid access:
  - no register changes;
  - err=1 one cycle later;
  - for a read, rdata <= 0 and rdata_valid=1 as well.
  - read_en and write_en both set and both invalid: a single err pulse.
- reg_out reflects the register contents combinationally from the flops (no extra latency).
- irq updates one cycle after any W1C register changes.

Test Plan:
- Reset with RESET_VALUES slice 3=0xDEAD_BEEF, then read 0x0C -> rdata=0xDEADBEEF, rdata_valid pulses for 1 cycle, err=0.
- Write 0xAABBCCDD with byte_strobe=4'b0101 to RW reg 0 (was 0) -> read 0x00 returns 0x00BB00DD.
- Set RO_MASK bit 1, host writes 0xFFFFFFFF to 0x04 -> value unchanged. Then hw_wr_en[1]=1, hw_wdata=0x1234 -> read 0x04 returns 0x1234.
- Set W1C_MASK bit 2, pulse hw_set bit 0 and bit 4 of reg 2 -> reg=0x11 and irq=1 the next cycle. Host writes 0x01 while hw_set bit 0 is pulsed -> reg stays 0x11. Host writes 0x11 -> reg=0, irq=0 one cycle later.
- Read addr 0x02 (unaligned), then addr 4*NUM_REGS -> each gives err=1, rdata=0, rdata_valid=1. Write to the same addresses -> err=1, no register changes.
- Write 0x55 then assert rst during a read of 0x00 -> next cycle rdata=0, rdata_valid=0, register back to its reset value.

Source files
------------

// File: rtl/apb_regfile_param.sv
// Parametrised host-accessible register file.
// Each register is RW, RO (hardware-loaded) or W1C (hardware-set, host-cleared).
// The host gets a registered read-data valid strobe and an error pulse for bad
// addresses. irq is the registered OR of all W1C register bits.
module apb_regfile_param #(
  parameter int                             DATA_WIDTH   = 32,
  parameter int                             ADDR_WIDTH   = 32,
  parameter int                             NUM_REGS     = 16,
  parameter int                             NBYTES       = DATA_WIDTH / 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK      = '0,
  parameter logic [NUM_REGS-1:0]            W1C_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           read_en,
  input  logic                           write_en,
  input  logic [NBYTES-1:0]              byte_strobe,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rdata_valid,
  output logic                           err,
  input  logic [NUM_REGS-1:0]            hw_wr_en,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic                           irq
);

  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WORD_W = ADDR_WIDTH - 2;

  logic [WORD_W-1:0]     w_word;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_addr_ok;
  logic [DATA_WIDTH-1:0] w_bmask;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [NUM_REGS-1:0]   w_wr_hit;
  logic [NUM_REGS-1:0]   w_w1c_nz;

  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdata_valid;
  logic                  r_err;
  logic                  r_irq;

  // The whole word address (not just the index field) is compared against
  // NUM_REGS, so any stray high address bit makes the access invalid.
  assign w_word    = addr[ADDR_WIDTH-1:2];
  assign w_idx     = w_word[IDX_W-1:0];
  assign w_addr_ok = (addr[1:0] == 2'b00) && (w_word < WORD_W'(NUM_REGS));

  genvar gi;

  for (gi = 0; gi < NBYTES; gi++) begin : g_bmask
    assign w_bmask[gi*8 +: 8] = {8{byte_strobe[gi]}};
  end

  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic IS_RO  = RO_MASK[gi];
    localparam logic IS_W1C = W1C_MASK[gi] & ~RO_MASK[gi];

    logic [DATA_WIDTH-1:0] r_val;

    assign w_wr_hit[gi] = write_en && w_addr_ok && (w_idx == IDX_W'(gi));
    assign w_regs[gi]   = r_val;
    assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_val;

    if (IS_RO) begin : g_ro
      logic w_unused_ro;
      assign w_unused_ro  = ^{hw_set[gi*DATA_WIDTH +: DATA_WIDTH], w_wr_hit[gi]};
      assign w_w1c_nz[gi] = 1'b0;

      // Read-only: only the hardware load strobe can change the value.
      always_ff @(posedge clk) begin
        if (rst)
          r_val <= RESET_VALUES[gi*DATA_WIDTH +: DATA_WIDTH];
        else if (hw_wr_en[gi])
          r_val <= hw_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (IS_W1C) begin : g_w1c
      logic w_unused_w1c;
      assign w_unused_w1c = ^{hw_wr_en[gi], hw_wdata[gi*DATA_WIDTH +: DATA_WIDTH]};
      assign w_w1c_nz[gi] = |r_val;

      // Write-1-to-clear; the hardware set is OR-ed after the clear so it wins.
      always_ff @(posedge clk) begin
        if (rst)
          r_val <= RESET_VALUES[gi*DATA_WIDTH +: DATA_WIDTH];
        else
          r_val <= (r_val & ~(w_wr_hit[gi] ? (wdata & w_bmask) : '0))
                 | hw_set[gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin : g_rw
      logic w_unused_rw;
      assign w_unused_rw  = ^{hw_wr_en[gi], hw_wdata[gi*DATA_WIDTH +: DATA_WIDTH],
                              hw_set[gi*DATA_WIDTH +: DATA_WIDTH]};
      assign w_w1c_nz[gi] = 1'b0;

      // Plain read/write register with byte-lane merge.
      always_ff @(posedge clk) begin
        if (rst)
          r_val <= RESET_VALUES[gi*DATA_WIDTH +: DATA_WIDTH];
        else if (w_wr_hit[gi])
          r_val <= (r_val & ~w_bmask) | (wdata & w_bmask);
      end
    end
  end

  // Read mux over all registers; out-of-range indices return zero.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_W'(i))
        w_rd_word = w_regs[i];
    end
  end

  // Host response: reads sample pre-write contents, bad accesses raise err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdata_valid <= read_en;
      r_err         <= (read_en | write_en) & ~w_addr_ok;
      if (read_en)
        r_rdata <= w_addr_ok ? w_rd_word : '0;
    end
  end

  // Interrupt follows W1C contents with one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst)
      r_irq <= 1'b0;
    else
      r_irq <= |w_w1c_nz;
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign err         = r_err;
  assign irq         = r_irq;

endmodule

// File: tb/tb_apb_regfile_param.sv
// Testbench for apb_regfile_param: directed scenarios followed by random
// traffic, checked against an array-based reference model and a response queue.
module tb_apb_regfile_param;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int N  = 12;
  localparam int NB = DW / 8;
  localparam logic [N-1:0] RO  = 12'h0A2;  // regs 1, 5, 7
  localparam logic [N-1:0] W1C = 12'h0C4;  // regs 2, 6, 7 (7 stays RO)
  localparam logic [N*DW-1:0] RV = ((N*DW)'(32'hDEADBEEF) << (3*DW))
                                 | ((N*DW)'(32'hCAFE0000) << (5*DW))
                                 | ((N*DW)'(32'h12345678) << (9*DW));

  typedef struct {
    logic          v;
    logic          e;
    logic [DW-1:0] d;
  } resp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   addr;
  logic            read_en;
  logic            write_en;
  logic [NB-1:0]   byte_strobe;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic            rdata_valid;
  logic            err;
  logic [N-1:0]    hw_wr_en;
  logic [N*DW-1:0] hw_wdata;
  logic [N*DW-1:0] hw_set;
  logic [N*DW-1:0] reg_out;
  logic            irq;

  logic [N*DW-1:0] rv_vec = RV;
  logic [N-1:0]    ro_v   = RO;
  logic [N-1:0]    w1c_v  = W1C;

  logic [DW-1:0]   m_reg [N];
  logic            m_irq;
  logic [DW-1:0]   m_rdata;
  resp_t           q [$];

  int checks = 0;
  int errors = 0;

  apb_regfile_param #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_REGS    (N),
    .RO_MASK     (RO),
    .W1C_MASK    (W1C),
    .RESET_VALUES(RV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .read_en    (read_en),
    .write_en   (write_en),
    .byte_strobe(byte_strobe),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .err        (err),
    .hw_wr_en   (hw_wr_en),
    .hw_wdata   (hw_wdata),
    .hw_set     (hw_set),
    .reg_out    (reg_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mode_of(input int i);
    if (ro_v[i]) return 1;
    if (w1c_v[i]) return 2;
    return 0;
  endfunction

  function automatic logic [N*DW-1:0] model_flat();
    logic [N*DW-1:0] f;
    for (int i = 0; i < N; i++) f[i*DW +: DW] = m_reg[i];
    return f;
  endfunction

  // Advances the reference model by one clock edge using the driven inputs.
  task automatic model_step();
    logic [DW-1:0] old [N];
    logic [DW-1:0] bm;
    logic [DW-1:0] v;
    logic          ok;
    logic          any;
    int            idx;
    resp_t         r;
    if (rst) begin
      for (int i = 0; i < N; i++) m_reg[i] = rv_vec[i*DW +: DW];
      m_irq   = 1'b0;
      m_rdata = '0;
      return;
    end
    old = m_reg;
    any = 1'b0;
    for (int i = 0; i < N; i++)
      if (mode_of(i) == 2 && old[i] != 0) any = 1'b1;
    m_irq = any;
    ok  = (addr[1:0] == 2'b00) && ((addr >> 2) < 32'(N));
    idx = ok ? int'(addr >> 2) : -1;
    for (int b = 0; b < NB; b++) bm[b*8 +: 8] = {8{byte_strobe[b]}};
    if (read_en) begin
      r.v = 1'b1;
      r.e = !ok;
      r.d = '0;
      if (ok) r.d = old[idx];
      q.push_back(r);
      m_rdata = r.d;
    end else if (write_en && !ok) begin
      r.v = 1'b0;
      r.e = 1'b1;
      r.d = '0;
      q.push_back(r);
    end
    for (int i = 0; i < N; i++) begin
      case (mode_of(i))
        0: if (write_en && idx == i) m_reg[i] = (old[i] & ~bm) | (wdata & bm);
        1: if (hw_wr_en[i]) m_reg[i] = hw_wdata[i*DW +: DW];
        default: begin
          v = old[i];
          if (write_en && idx == i) v = v & ~(wdata & bm);
          m_reg[i] = v | hw_set[i*DW +: DW];
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rst         = 1'b0;
    read_en     = 1'b0;
    write_en    = 1'b0;
    byte_strobe = '0;
    hw_wr_en    = '0;
    hw_set      = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] bs);
    addr = a; wdata = d; byte_strobe = bs; write_en = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    addr = a; read_en = 1'b1;
    tick();
    idle();
  endtask

  // Monitor: pops one expected response per output pulse, tracks state every cycle.
  initial begin
    resp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rdata_valid || err) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {rdata_valid, err}, 2'b00);
        end else begin
          e = q.pop_front();
          chk("resp_valid", rdata_valid, e.v);
          chk("resp_err", err, e.e);
          if (e.v) chk("resp_rdata", rdata, e.d);
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        chk("missing_pulse", {rdata_valid, err}, {e.v, e.e});
      end
      chk("rdata_hold", rdata, m_rdata);
      chk("irq", irq, m_irq);
      chk("reg_out", reg_out, model_flat());
    end
  end

  initial begin
    logic [N*DW-1:0] snap;
    int sel;
    addr = '0; wdata = '0; hw_wdata = '0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    idle();
    chk("reset_regout", reg_out, RV);
    chk("reset_rdata", rdata, 0);
    chk("reset_valid", rdata_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_irq", irq, 0);

    // Reset value readback.
    rd(32'h0C);
    chk("rd_0c_data", rdata, 32'hDEADBEEF);
    chk("rd_0c_valid", rdata_valid, 1);
    chk("rd_0c_err", err, 0);
    tick();
    chk("rd_0c_valid_drop", rdata_valid, 0);

    // Byte-strobed RW write.
    wr(32'h00, 32'hAABBCCDD, 4'b0101);
    rd(32'h00);
    chk("rw_strobe", rdata, 32'h00BB00DD);

    // RO register: host write ignored, hardware load accepted.
    wr(32'h04, 32'hFFFFFFFF, 4'hF);
    chk("ro_host_ignored", reg_out[1*DW +: DW], 0);
    hw_wr_en[1] = 1'b1;
    hw_wdata[1*DW +: DW] = 32'h1234;
    tick();
    idle();
    rd(32'h04);
    chk("ro_hw_load", rdata, 32'h1234);

    // W1C register: set, simultaneous set/clear, clear.
    hw_set[2*DW +: DW] = 32'h11;
    tick();
    idle();
    chk("w1c_set", reg_out[2*DW +: DW], 32'h11);
    tick();
    chk("w1c_irq_on", irq, 1);
    addr = 32'h08; wdata = 32'h01; byte_strobe = 4'hF; write_en = 1'b1;
    hw_set[2*DW +: DW] = 32'h01;
    tick();
    idle();
    chk("w1c_set_wins", reg_out[2*DW +: DW], 32'h11);
    wr(32'h08, 32'h11, 4'hF);
    chk("w1c_clear", reg_out[2*DW +: DW], 0);
    tick();
    chk("w1c_irq_off", irq, 0);

    // Invalid accesses.
    rd(32'h02);
    chk("unaligned_rd_err", err, 1);
    chk("unaligned_rd_data", rdata, 0);
    chk("unaligned_rd_valid", rdata_valid, 1);
    rd(32'(4*N));
    chk("oor_rd_err", err, 1);
    chk("oor_rd_data", rdata, 0);
    chk("oor_rd_valid", rdata_valid, 1);
    snap = model_flat();
    wr(32'h02, 32'hFFFFFFFF, 4'hF);
    chk("unaligned_wr_err", err, 1);
    wr(32'(4*N), 32'hFFFFFFFF, 4'hF);
    chk("oor_wr_err", err, 1);
    chk("invalid_wr_nochange", reg_out, snap);

    // Reset during a read drops the response.
    wr(32'h00, 32'h55, 4'hF);
    addr = 32'h00; read_en = 1'b1; rst = 1'b1;
    tick();
    idle();
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_valid", rdata_valid, 0);
    chk("rst_mid_reg0", reg_out[0 +: DW], 0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)
        addr = 32'($urandom_range(0, N-1)) << 2;
      else if (sel == 7)
        addr = (32'($urandom_range(0, N-1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8)
        addr = 32'($urandom_range(N, N+5)) << 2;
      else
        addr = (32'(1) << $urandom_range(6, 31)) | (32'($urandom_range(0, N-1)) << 2);
      read_en     = 1'($urandom);
      write_en    = 1'($urandom);
      byte_strobe = NB'($urandom);
      wdata       = $urandom;
      hw_wr_en    = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        hw_wdata[i*DW +: DW] = $urandom;
        hw_set[i*DW +: DW]   = $urandom & $urandom & $urandom;
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle();
    tick();
    tick();
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
